// File: rtl/search_seq_avalon_if.sv
// search_seq_avalon_if
// Groups the Avalon-MM slave register port and the search-memory read port
// of search_seq_avalon.
//   chipselect/address/write/writedata/byteenable/read : register access in
//   readdata    : combinational register read data
//   mem_addr    : word address presented to the search memory
//   mem_rd      : one-cycle memory read request
//   mem_rdata   : memory read data
//   mem_rvalid  : mem_rdata valid strobe
//   irq         : level interrupt (DONE & IEN)
// Modport slave is the search engine side, master is the host/memory side.
interface search_seq_avalon_if #(
    parameter int AW = 16
);
    logic          chipselect;
    logic [2:0]    address;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic          read;
    logic [31:0]   readdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          irq;

    modport slave (
        input  chipselect, address, write, writedata, byteenable, read,
        input  mem_rdata, mem_rvalid,
        output readdata, mem_addr, mem_rd, irq
    );

    modport master (
        output chipselect, address, write, writedata, byteenable, read,
        output mem_rdata, mem_rvalid,
        input  readdata, mem_addr, mem_rd, irq
    );
endinterface

// File: rtl/search_seq_avalon.sv
// search_seq_avalon
// Sequential linear search engine. Software programs KEY, BASE and LENGTH
// through the register port, writes START, and the engine reads memory words
// BASE+idx (wrapping modulo 2^AW) one at a time until a word equals KEY or
// LENGTH words have been examined. RESULT holds the matching index (or all
// ones when nothing matched) and COUNT the number of words compared.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : search_seq_avalon_if.slave (register port, memory port, irq)
// Register map (word address):
//   0 CTRL   bit0 START (pulse), bit1 ABORT (pulse), bit2 IEN
//   1 STATUS bit0 BUSY, bit1 DONE, bit2 FOUND (read-only)
//   2 KEY, 3 BASE, 4 LENGTH, 5 RESULT (ro), 6 COUNT (ro), 7 reads 0
module search_seq_avalon #(
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    search_seq_avalon_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;

    state_t        state;
    logic [31:0]   key_q;
    logic [AW-1:0] base_q;
    logic [AW:0]   length_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   idx_inc;
    logic [31:0]   result_q;
    logic [31:0]   count_q;
    logic [31:0]   rdata_q;
    logic          ien_q;
    logic          busy_q;
    logic          done_q;
    logic          found_q;

    logic          wr_en;
    logic          ctrl_wr;
    logic          start_req;
    logic          abort_req;
    logic [31:0]   be_mask;

    assign idx_inc   = idx_q + {{AW{1'b0}}, 1'b1};
    assign wr_en     = bus.chipselect & bus.write;
    // START/ABORT/IEN all live in byte 0, so a CTRL write without byte 0 does nothing.
    assign ctrl_wr   = wr_en && (bus.address == 3'd0) && bus.byteenable[0];
    // ABORT wins over a simultaneous START, even when the engine is idle.
    assign start_req = ctrl_wr & bus.writedata[0] & ~bus.writedata[1];
    assign abort_req = ctrl_wr & bus.writedata[1];
    assign be_mask   = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                        {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

    assign bus.irq   = done_q & ien_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            key_q       <= '0;
            base_q      <= '0;
            length_q    <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            ien_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
        end else begin
            bus.mem_rd <= 1'b0;

            if (ctrl_wr) begin
                ien_q <= bus.writedata[2];
            end

            // Search parameters are frozen while a search is running.
            if (wr_en && !busy_q) begin
                case (bus.address)
                    3'd2: key_q    <= (bus.writedata & be_mask) | (key_q & ~be_mask);
                    3'd3: base_q   <= (bus.writedata[AW-1:0] & be_mask[AW-1:0]) |
                                      (base_q & ~be_mask[AW-1:0]);
                    3'd4: length_q <= (bus.writedata[AW:0] & be_mask[AW:0]) |
                                      (length_q & ~be_mask[AW:0]);
                    default: ;
                endcase
            end

            if (abort_req && state != IDLE) begin
                // COUNT is deliberately left alone so software sees progress.
                state    <= IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                found_q  <= 1'b0;
                result_q <= 32'hFFFF_FFFF;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req) begin
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            found_q <= 1'b0;
                            idx_q   <= '0;
                            count_q <= '0;
                            if (length_q == '0) begin
                                state <= FINISH;
                            end else begin
                                state        <= ISSUE;
                                bus.mem_rd   <= 1'b1;
                                bus.mem_addr <= base_q;
                            end
                        end
                    end
                    ISSUE: state <= WAIT;
                    // mem_rvalid is only looked at here, so stale responses are dropped.
                    WAIT: begin
                        if (bus.mem_rvalid) begin
                            rdata_q <= bus.mem_rdata;
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        count_q <= count_q + 32'd1;
                        if (rdata_q == key_q) begin
                            result_q <= {{(31-AW){1'b0}}, idx_q};
                            found_q  <= 1'b1;
                            state    <= FINISH;
                        end else if (idx_inc == length_q) begin
                            state <= FINISH;
                        end else begin
                            idx_q        <= idx_inc;
                            bus.mem_addr <= base_q + idx_inc[AW-1:0];
                            bus.mem_rd   <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                    FINISH: begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        if (!found_q) begin
                            result_q <= 32'hFFFF_FFFF;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect && bus.read) begin
            case (bus.address)
                3'd0: bus.readdata = {29'd0, ien_q, 2'b00};
                3'd1: bus.readdata = {29'd0, found_q, done_q, busy_q};
                3'd2: bus.readdata = key_q;
                3'd3: bus.readdata = {{(32-AW){1'b0}}, base_q};
                3'd4: bus.readdata = {{(31-AW){1'b0}}, length_q};
                3'd5: bus.readdata = result_q;
                3'd6: bus.readdata = count_q;
                default: bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_search_seq_avalon.sv
// tb_search_seq_avalon
// Directed bench for search_seq_avalon. A behavioural memory answers mem_rd
// after a programmable latency with data derived from the address. Expected
// register/pin values and expected memory read addresses are queued when the
// stimulus is issued and popped when the DUT produces the matching output.
module tb_search_seq_avalon;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    search_seq_avalon_if #(.AW(AW)) bus ();

    search_seq_avalon #(.AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            n_asserts = 0;
    int            n_fail    = 0;
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            rd_count  = 0;
    int            latency   = 1;
    int            pend      = 0;
    int            lat_cnt   = 0;
    logic [AW-1:0] pend_addr;
    logic [AW-1:0] exp_a;

    // Memory contents: 0x10..0x17 hold 0xCAFE0000+i, everything else ~addr.
    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] ax;
        ax = {{(32-AW){1'b0}}, a};
        if (ax >= 32'h10 && ax <= 32'h17) return 32'hCAFE_0000 + (ax - 32'h10);
        return ~ax;
    endfunction

    // Memory responder and read-address monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bus.mem_rvalid = 1'b0;
        if (pend != 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_word(pend_addr);
                pend = 0;
            end
        end
        if (bus.mem_rd === 1'b1) begin
            rd_count  = rd_count + 1;
            pend      = 1;
            lat_cnt   = latency;
            pend_addr = bus.mem_addr;
            n_asserts = n_asserts + 1;
            if (exp_addr_q.size() == 0) begin
                n_fail = n_fail + 1;
                $error("[TB] FAIL mem_rd_unexpected: observed addr %h, expected no read", bus.mem_addr);
            end else begin
                exp_a = exp_addr_q.pop_front();
                assert (bus.mem_addr === exp_a) else begin
                    n_fail = n_fail + 1;
                    $error("[TB] FAIL mem_addr: observed %h expected %h", bus.mem_addr, exp_a);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data,
                                 input logic [3:0] be);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = be;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        n_asserts = n_asserts + 1;
        if (exp_q.size() == 0) begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL %s: observed %h, no expected value queued", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) else begin
                n_fail = n_fail + 1;
                $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    task automatic checkReg(input string tag, input logic [2:0] addr, input logic [31:0] expv);
        logic [31:0] d;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        checkOutput(tag, d);
    endtask

    task automatic pushAddrs(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            a = a + 1'b1;
        end
    endtask

    // Counts rising edges after the START write until STATUS.DONE reads 1.
    task automatic waitDone(output int cycles);
        cycles = -1;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 3'd1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (bus.readdata[1] === 1'b1) begin
                cycles = k;
                break;
            end
        end
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        exp_q.push_back(32'd0); checkOutput("mem_rd_after_reset", {31'd0, bus.mem_rd});
        exp_q.push_back(32'd0); checkOutput("mem_addr_after_reset", {{(32-AW){1'b0}}, bus.mem_addr});
        exp_q.push_back(32'd0); checkOutput("irq_after_reset", {31'd0, bus.irq});
        for (int a = 0; a < 8; a++) checkReg($sformatf("reset_reg%0d", a), 3'(a), 32'd0);

        $display("[TB] search with hit at index 3");
        latency = 1;
        applyStimulus(3'd2, 32'hCAFE_0003, 4'hF);
        applyStimulus(3'd3, 32'h0000_0010, 4'hF);
        applyStimulus(3'd4, 32'h0000_0008, 4'hF);
        pushAddrs(16'h0010, 4);
        rd_count = 0;
        applyStimulus(3'd0, 32'h1, 4'h1);
        exp_q.push_back(32'd13);
        waitDone(cyc);
        checkOutput("hit_done_latency", 32'(cyc));
        checkReg("hit_status", 3'd1, 32'h6);
        checkReg("hit_result", 3'd5, 32'd3);
        checkReg("hit_count", 3'd6, 32'd4);
        exp_q.push_back(32'd4); checkOutput("hit_rd_pulses", 32'(rd_count));

        $display("[TB] search with absent key");
        applyStimulus(3'd2, 32'h1234_5678, 4'hF);
        pushAddrs(16'h0010, 8);
        applyStimulus(3'd0, 32'h1, 4'h1);
        exp_q.push_back(32'd25);
        waitDone(cyc);
        checkOutput("miss_done_latency", 32'(cyc));
        checkReg("miss_status", 3'd1, 32'h2);
        checkReg("miss_result", 3'd5, 32'hFFFF_FFFF);
        checkReg("miss_count", 3'd6, 32'd8);

        $display("[TB] zero length and register masking");
        applyStimulus(3'd4, 32'h0, 4'hF);
        rd_count = 0;
        applyStimulus(3'd0, 32'h1, 4'h1);
        exp_q.push_back(32'd1);
        waitDone(cyc);
        checkOutput("len0_done_latency", 32'(cyc));
        checkReg("len0_status", 3'd1, 32'h2);
        exp_q.push_back(32'd0); checkOutput("len0_rd_pulses", 32'(rd_count));
        applyStimulus(3'd2, 32'hAABB_CCDD, 4'b0101);
        checkReg("key_byteenable", 3'd2, 32'h12BB_56DD);
        applyStimulus(3'd4, 32'hFFFE_0004, 4'hF);
        checkReg("length_mask", 3'd4, 32'h0000_0004);
        applyStimulus(3'd3, 32'hFFFF_FFFE, 4'hF);
        checkReg("base_mask", 3'd3, 32'h0000_FFFE);

        $display("[TB] address wrap");
        pushAddrs(16'hFFFE, 4);
        applyStimulus(3'd0, 32'h1, 4'h1);
        exp_q.push_back(32'd13);
        waitDone(cyc);
        checkOutput("wrap_done_latency", 32'(cyc));
        checkReg("wrap_count", 3'd6, 32'd4);
        checkReg("wrap_result", 3'd5, 32'hFFFF_FFFF);

        $display("[TB] abort with slow memory");
        latency = 5;
        applyStimulus(3'd2, 32'h1234_5678, 4'hF);
        applyStimulus(3'd3, 32'h0000_0010, 4'hF);
        applyStimulus(3'd4, 32'h0000_0008, 4'hF);
        pushAddrs(16'h0010, 3);
        rd_count = 0;
        applyStimulus(3'd0, 32'h1, 4'h1);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (rd_count == 3) break;
        end
        exp_q.push_back(32'd3); checkOutput("abort_reads_before", 32'(rd_count));
        applyStimulus(3'd2, 32'h0000_0000, 4'hF);
        applyStimulus(3'd0, 32'h2, 4'h1);
        checkReg("abort_status", 3'd1, 32'h2);
        checkReg("abort_count", 3'd6, 32'd2);
        checkReg("abort_result", 3'd5, 32'hFFFF_FFFF);
        checkReg("key_write_while_busy", 3'd2, 32'h1234_5678);
        repeat (8) @(posedge clk);
        checkReg("abort_late_rvalid_status", 3'd1, 32'h2);
        checkReg("abort_late_rvalid_count", 3'd6, 32'd2);
        applyStimulus(3'd0, 32'h1, 4'b1110);
        repeat (3) @(posedge clk);
        checkReg("start_without_byte0", 3'd1, 32'h2);
        exp_q.push_back(32'd3); checkOutput("start_without_byte0_reads", 32'(rd_count));

        $display("[TB] interrupt and mid-search reset");
        latency = 1;
        applyStimulus(3'd2, 32'hCAFE_0003, 4'hF);
        applyStimulus(3'd0, 32'h4, 4'h1);
        pushAddrs(16'h0010, 4);
        applyStimulus(3'd0, 32'h5, 4'h1);
        exp_q.push_back(32'd0); checkOutput("irq_during_search", {31'd0, bus.irq});
        exp_q.push_back(32'd13);
        waitDone(cyc);
        checkOutput("irq_search_latency", 32'(cyc));
        exp_q.push_back(32'd1); checkOutput("irq_after_done", {31'd0, bus.irq});
        pushAddrs(16'h0010, 1);
        applyStimulus(3'd0, 32'h5, 4'h1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset          = 1'b1;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h5;
        bus.byteenable = 4'h1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;
        exp_q.push_back(32'd0); checkOutput("irq_after_reset2", {31'd0, bus.irq});
        exp_q.push_back(32'd0); checkOutput("mem_rd_reset_cycle", {31'd0, bus.mem_rd});
        exp_q.push_back(32'd0); checkOutput("mem_addr_reset2", {{(32-AW){1'b0}}, bus.mem_addr});
        @(posedge clk);
        #1;
        exp_q.push_back(32'd0); checkOutput("mem_rd_cycle_after_reset", {31'd0, bus.mem_rd});
        for (int a = 0; a < 8; a++) checkReg($sformatf("reset2_reg%0d", a), 3'(a), 32'd0);

        repeat (10) @(posedge clk);
        n_asserts = n_asserts + 1;
        assert (exp_addr_q.size() == 0) else begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL addr_queue_drained: observed %0d reads outstanding, expected 0",
                   exp_addr_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
